ceespu_branch_update_ctrl: RTL

- Sequences training of the gshare branch predictor and recovery from branch mispredictions.
- Fetch pushes each predicted branch into an in-order tracking FIFO: address, 2-bit table state read at prediction time, predicted direction.
- Execute resolves branches oldest-first. The block compares outcome against prediction, drives the predictor's update port, and on mispredict flushes wrong-path entries and issues a redirect.
- Sits between fetch, execute and the predictor. Keeps saturating statistics counters.

---
 rtl/ceespu_branch_update_ctrl_if.sv | 26 ++
 rtl/ceespu_branch_update_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/ceespu_branch_update_ctrl_if.sv
// Fetch/execute side bundle for the branch update controller.
//   enq_*  : fetch pushes a predicted branch (valid/ready handshake)
//   res_*  : execute resolves the oldest outstanding branch
// master modport: fetch/execute driver; slave modport: the controller.
interface ceespu_branch_update_ctrl_if;
    logic        enq_valid;
    logic        enq_ready;
    logic [15:0] enq_address;
    logic [1:0]  enq_state;
    logic        enq_prediction;
    logic        res_valid;
    logic        res_taken;
    logic [15:0] res_target;

    modport master (
        output enq_valid, enq_address, enq_state, enq_prediction,
        output res_valid, res_taken, res_target,
        input  enq_ready
    );

    modport slave (
        input  enq_valid, enq_address, enq_state, enq_prediction,
        input  res_valid, res_taken, res_target,
        output enq_ready
    );
endinterface

// File: rtl/ceespu_branch_update_ctrl.sv
// Gshare training / misprediction recovery controller.
// Tracks predicted branches in an in-order FIFO, compares each resolved
// outcome against its prediction, strobes the predictor update port and,
// on a mispredict, flushes wrong-path entries and issues a redirect.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   bus (slave)              : enq_* push from fetch, res_* resolve from execute
//   update_table             : one-cycle predictor write strobe
//   branch_address/_prediction_state/_taken : predictor update payload
//   flush, redirect_address  : one-cycle flush pulse and correct fetch address
//   outstanding              : FIFO occupancy
//   stat_branches/_mispredicts : saturating statistics
module ceespu_branch_update_ctrl #(
    parameter int DEPTH_LOG2   = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    ceespu_branch_update_ctrl_if.slave bus,
    output logic                   update_table,
    output logic [15:0]            branch_address,
    output logic [1:0]             branch_prediction_state,
    output logic                   branch_taken,
    output logic                   flush,
    output logic [15:0]            redirect_address,
    output logic [DEPTH_LOG2:0]    outstanding,
    output logic [15:0]            stat_branches,
    output logic [15:0]            stat_mispredicts
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0]            state;
    logic [3:0]            flush_cnt;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;

    logic [15:0] addr_mem [DEPTH];
    logic [1:0]  state_mem [DEPTH];
    logic        pred_mem [DEPTH];

    logic        push;
    logic        pop;
    logic        mispredict;
    logic [15:0] head_addr;
    logic [1:0]  head_state;
    logic        head_pred;

    // Occupancy never exceeds DEPTH, so the MSB alone marks "full".
    assign bus.enq_ready = (state == ST_RUN) && !outstanding[DEPTH_LOG2];

    always_comb begin
        head_addr  = addr_mem[rd_ptr];
        head_state = state_mem[rd_ptr];
        head_pred  = pred_mem[rd_ptr];
        push       = bus.enq_valid && bus.enq_ready;
        pop        = bus.res_valid && (state == ST_RUN) && (outstanding != '0);
        mispredict = pop && (bus.res_taken != head_pred);
    end

    // Storage needs no reset; validity is tracked by the pointers/occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr]  <= bus.enq_address;
            state_mem[wr_ptr] <= bus.enq_state;
            pred_mem[wr_ptr]  <= bus.enq_prediction;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
        end else if (mispredict) begin
            // Everything still queued is wrong-path, including a same-cycle push.
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (pop)
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            if (push && !pop)
                outstanding <= outstanding + (DEPTH_LOG2+1)'(1);
            else if (pop && !push)
                outstanding <= outstanding - (DEPTH_LOG2+1)'(1);
        end
    end

    // FLUSH holds for exactly FLUSH_CYCLES cycles: leave after the cycle
    // in which the counter reads 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            flush_cnt <= '0;
        end else if (state == ST_RUN) begin
            if (mispredict) begin
                state     <= ST_FLUSH;
                flush_cnt <= 4'(FLUSH_CYCLES);
            end
        end else begin
            if (flush_cnt == 4'd1)
                state <= ST_RUN;
            else
                flush_cnt <= flush_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            update_table            <= 1'b0;
            flush                   <= 1'b0;
            branch_address          <= '0;
            branch_prediction_state <= '0;
            branch_taken            <= 1'b0;
            redirect_address        <= '0;
            stat_branches           <= '0;
            stat_mispredicts        <= '0;
        end else begin
            update_table <= pop;
            flush        <= mispredict;
            if (pop) begin
                branch_address          <= head_addr;
                branch_prediction_state <= head_state;
                branch_taken            <= bus.res_taken;
                if (stat_branches != '1)
                    stat_branches <= stat_branches + 16'd1;
            end
            if (mispredict) begin
                redirect_address <= bus.res_taken ? bus.res_target : head_addr + 16'd4;
                if (stat_mispredicts != '1)
                    stat_mispredicts <= stat_mispredicts + 16'd1;
            end
        end
    end
endmodule
